id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded instructions, forwards operands from
// EX/MEM and MEM/WB, and raises a one-cycle load-use hazard stall towards decode.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_rs_data,
  input  logic [31:0] in_rt_data,
  input  logic [31:0] in_imm,
  input  logic        in_use_imm,
  input  logic [2:0]  in_alu_op,
  input  logic [4:0]  in_sa,
  input  logic        in_reg_we,
  input  logic        in_mem_rd,
  input  logic        in_mem_we,
  input  logic        exmem_we,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_res,
  input  logic        memwb_we,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_data,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  output logic [4:0]  alu_sa,
  output logic        out_valid,
  output logic        out_reg_we,
  output logic        out_mem_rd,
  output logic        out_mem_we,
  output logic [4:0]  out_rd,
  output logic [31:0] out_store_data,
  output logic        hazard_stall
);

  logic        valid_q;
  logic [4:0]  rs_q;
  logic [4:0]  rt_q;
  logic [4:0]  rd_q;
  logic [31:0] rs_data_q;
  logic [31:0] rt_data_q;
  logic [31:0] imm_q;
  logic        use_imm_q;
  logic [2:0]  alu_op_q;
  logic [4:0]  sa_q;
  logic        reg_we_q;
  logic        mem_rd_q;
  logic        mem_we_q;

  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [31:0] byp_a;
  logic [31:0] byp_b;

  // EX/MEM outranks MEM/WB because it holds the younger producer; r0 never forwards.
  always_comb begin
    fwd_a = rs_data_q;
    if (exmem_we && exmem_rd != 5'd0 && exmem_rd == rs_q)
      fwd_a = exmem_res;
    else if (memwb_we && memwb_rd != 5'd0 && memwb_rd == rs_q)
      fwd_a = memwb_data;

    fwd_b = rt_data_q;
    if (exmem_we && exmem_rd != 5'd0 && exmem_rd == rt_q)
      fwd_b = exmem_res;
    else if (memwb_we && memwb_rd != 5'd0 && memwb_rd == rt_q)
      fwd_b = memwb_data;
  end

  // Write-back happening this cycle is not yet visible in the register file read.
  always_comb begin
    byp_a = in_rs_data;
    if (memwb_we && memwb_rd != 5'd0 && memwb_rd == in_rs)
      byp_a = memwb_data;

    byp_b = in_rt_data;
    if (memwb_we && memwb_rd != 5'd0 && memwb_rd == in_rt)
      byp_b = memwb_data;
  end

  always_comb begin
    hazard_stall = in_valid && valid_q && mem_rd_q && (rd_q != 5'd0) &&
                   ((in_rs == rd_q) || ((!in_use_imm || in_mem_we) && (in_rt == rd_q)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      rs_q      <= 5'd0;
      rt_q      <= 5'd0;
      rd_q      <= 5'd0;
      rs_data_q <= 32'd0;
      rt_data_q <= 32'd0;
      imm_q     <= 32'd0;
      use_imm_q <= 1'b0;
      alu_op_q  <= 3'd0;
      sa_q      <= 5'd0;
      reg_we_q  <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_we_q  <= 1'b0;
    end else if (flush || (!stall && hazard_stall)) begin
      valid_q  <= 1'b0;
      reg_we_q <= 1'b0;
      mem_rd_q <= 1'b0;
      mem_we_q <= 1'b0;
    end else if (stall) begin
      // Recapture forwarded operands so a producer retiring during the stall is kept.
      rs_data_q <= fwd_a;
      rt_data_q <= fwd_b;
    end else begin
      valid_q   <= in_valid;
      rs_q      <= in_rs;
      rt_q      <= in_rt;
      rd_q      <= in_rd;
      rs_data_q <= byp_a;
      rt_data_q <= byp_b;
      imm_q     <= in_imm;
      use_imm_q <= in_use_imm;
      alu_op_q  <= in_alu_op;
      sa_q      <= in_sa;
      reg_we_q  <= in_reg_we;
      mem_rd_q  <= in_mem_rd;
      mem_we_q  <= in_mem_we;
    end
  end

  assign alu_a          = fwd_a;
  assign alu_b          = use_imm_q ? imm_q : fwd_b;
  assign out_store_data = fwd_b;
  assign alu_op         = alu_op_q;
  assign alu_sa         = sa_q;
  assign out_rd         = rd_q;
  assign out_valid      = valid_q;
  assign out_reg_we     = valid_q & reg_we_q;
  assign out_mem_rd     = valid_q & mem_rd_q;
  assign out_mem_we     = valid_q & mem_we_q;

endmodule
